// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch debouncer.
package debounce_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE_LOW  = 2'd0;
    localparam state_t WAIT_HIGH = 2'd1;
    localparam state_t IDLE_HIGH = 2'd2;
    localparam state_t WAIT_LOW  = 2'd3;

    // 10 ms at 100 MHz
    localparam int DEFAULT_STABLE_COUNT = 1000000;
    localparam int DEFAULT_CNT_WIDTH    = 20;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer for asynchronous board inputs; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce_fsm.sv
// Switch debouncer: 2-flop sync, 4-state FSM, stability counter.
// Define DEBOUNCE_EDGE_PULSE_EN to build the rise/fall pulse registers.
module debounce_fsm
    import debounce_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic                 s2;
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 done_high;
    logic                 done_low;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (switch),
        .q     (s2)
    );

    // The new level has survived the full stability window this cycle.
    assign done_high = (state == WAIT_HIGH) && s2 && (cnt == CNT_LAST);
    assign done_low  = (state == WAIT_LOW) && !s2 && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            clean <= 1'b0;
        end else begin
            case (state)
                IDLE_LOW: begin
                    if (s2) begin
                        state <= WAIT_HIGH;
                        cnt   <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s2) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end else if (done_high) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                        clean <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!s2) begin
                        state <= WAIT_LOW;
                        cnt   <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s2) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                    end else if (done_low) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                        clean <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_EDGE_PULSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= done_high;
            fall <= done_low;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm with a run-length reference model.
module tb_debounce_fsm;

    localparam int SC = 4;
    localparam int CW = 3;

    logic clk;
    logic rst_n;
    logic switch;
    logic clean;
    logic rise;
    logic fall;

    int checks;
    int errors;

    // Reference model: switch history delayed two edges, plus a run length
    // of consecutive edges on which the delayed level disagreed with clean.
    logic pipe[$];
    int   run;
    logic m_clean;
    logic m_rise;
    logic m_fall;

    debounce_fsm #(
        .STABLE_COUNT (SC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .switch (switch),
        .clean  (clean),
        .rise   (rise),
        .fall   (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        pipe.push_back(1'b0);
        pipe.push_back(1'b0);
        run     = 0;
        m_clean = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
    endtask

    task automatic model_update();
        logic seen;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seen = pipe.pop_front();
        pipe.push_back(switch);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (seen != m_clean) begin
            run++;
            if (run == SC + 1) begin
                m_clean = seen;
                m_rise  = seen;
                m_fall  = !seen;
                run     = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_clean"}, 32'(clean), 32'(m_clean));
`ifdef DEBOUNCE_EDGE_PULSE_EN
        check({tag, "_rise"}, 32'(rise), 32'(m_rise));
        check({tag, "_fall"}, 32'(fall), 32'(m_fall));
`else
        check({tag, "_rise"}, 32'(rise), 32'd0);
        check({tag, "_fall"}, 32'(fall), 32'd0);
`endif
        check({tag, "_excl"}, 32'(rise & fall), 32'd0);
    endtask

    // Called just after a negedge: drive, take one posedge, check at next negedge.
    task automatic step(input logic sw, input string tag);
        switch = sw;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic hold(input logic sw, input int n, input string tag);
        for (int i = 0; i < n; i++) step(sw, tag);
    endtask

    // Directed edge check independent of the model: clean flips on edge SC+3.
    task automatic expect_flip(input logic lvl, input string tag);
        hold(lvl, SC + 2, tag);
        check({tag, "_before"}, 32'(clean), 32'(!lvl));
        step(lvl, tag);
        check({tag, "_edge7"}, 32'(clean), 32'(lvl));
`ifdef DEBOUNCE_EDGE_PULSE_EN
        check({tag, "_pulse"}, 32'(lvl ? rise : fall), 32'd1);
`endif
        step(lvl, tag);
        check({tag, "_pulse_end"}, 32'(rise | fall), 32'd0);
    endtask

    initial begin
        logic lvl;
        int   len;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        switch = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset held with switch high: outputs stay cleared.
        hold(1'b1, 10, "rst_hold");
        rst_n = 1'b1;
        hold(1'b0, 3, "settle");

        // Clean press, then release.
        expect_flip(1'b1, "press");
        hold(1'b1, 3, "press_hold");
        expect_flip(1'b0, "release");

        // Asynchronous reset mid-cycle while clean is high.
        expect_flip(1'b1, "press2");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_clean", 32'(clean), 32'd0);
        check("async_rise", 32'(rise), 32'd0);
        check("async_fall", 32'(fall), 32'd0);
        @(negedge clk);
        hold(1'b0, 2, "async_hold");
        rst_n = 1'b1;
        hold(1'b0, 3, "settle2");

        // Reset while counting in WAIT_HIGH (cnt=2): partial count discarded.
        hold(1'b1, 5, "mid_count");
        check("mid_count_clean", 32'(clean), 32'd0);
        rst_n = 1'b0;
        hold(1'b1, 2, "mid_rst");
        rst_n = 1'b1;
        expect_flip(1'b1, "after_rst");

        // Bounce: high 3, low 1, high held.
        hold(1'b0, 10, "to_low");
        check("to_low_clean", 32'(clean), 32'd0);
        hold(1'b1, 3, "bounce_hi");
        step(1'b0, "bounce_lo");
        expect_flip(1'b1, "bounce");

        // Random bursts against the model, with an occasional reset.
        for (int b = 0; b < 120; b++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 40) == 0) rst_n = 1'b0;
            hold(lvl, len, "rand");
            rst_n = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
Debounces a raw mechanical switch/button and produces the stable `clean` level consumed by the downstream clean/clock select mux. The raw input passes through a 2-flop synchronizer into a 4-state FSM with a stability counter. Optional single-cycle edge pulses are available for step-style logic.

Parameters:
STABLE_COUNT, 1000000, number of consecutive clk cycles the synchronized input must hold a new level before `clean` follows it (10 ms at 100 MHz); legal range 1 to 2^CNT_WIDTH.
CNT_WIDTH, 20, width of the stability counter.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  reset; asynchronous, active-low.
switch  input  1  raw, unsynchronized switch/button level.
clean  output  1  debounced level; feeds the mux `clean` input.
rise  output  1  one-cycle pulse when `clean` goes 0->1.
fall  output  1  one-cycle pulse when `clean` goes 1->0.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clk needed): sync flops=0, state=IDLE_LOW, cnt=0, clean=0, rise=0, fall=0. Reset mid-count discards the partial count. No transition occurs on the first clk edge after release other than normal sampling.
- Synchronizer: s1<=switch, s2<=s1; `s2` is the only FSM input.
- States:
  - IDLE_LOW: clean=0. If s2=1, go to WAIT_HIGH with cnt<=0.
  - WAIT_HIGH: if s2=0, go to IDLE_LOW with cnt<=0 (glitch rejected). Else if cnt==STABLE_COUNT-1, go to IDLE_HIGH and register clean<=1, rise<=1. Else cnt<=cnt+1.
  - IDLE_HIGH: clean=1. If s2=0, go to WAIT_LOW with cnt<=0.
  - WAIT_LOW: mirror of WAIT_HIGH. s2=1 returns to IDLE_HIGH. On cnt==STABLE_COUNT-1, go to IDLE_LOW and register clean<=0, fall<=1.
- clean, rise and fall are registered. rise and fall are high for exactly one cycle and are never high simultaneously.
- Latency: for a raw level held stable from before posedge 1, clean changes at posedge STABLE_COUNT+3:
  - 2 cycles for synchronization,
  - 1 cycle to enter WAIT,
  - STABLE_COUNT cycles of counting.
- Glitch: any s2 reversal during WAIT leaves clean unchanged and restarts the count from zero on the next qualifying edge.
- Counter never wraps; it is compared and cleared before reaching 2^CNT_WIDTH-1 given the legal STABLE_COUNT range.
- STABLE_COUNT=1: transition occurs on the cycle after entering WAIT.

Optional Feature:
Macro DEBOUNCE_EDGE_PULSE_EN.
- Defined: rise/fall generated as specified above.
- Undefined: rise and fall are tied to constant 0; the pulse registers are not built; clean timing is unchanged. Ports remain present in both builds.

Decomposition:
- Package debounce_pkg: state typedef (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW, 2-bit encoding), default STABLE_COUNT/CNT_WIDTH constants.
- One natural sub-module: sync_2ff (1-bit two-flop synchronizer, clk/rst_n/d/q, reset value 0), reusable for other board inputs.

Test Plan:
All scenarios use STABLE_COUNT=4, CNT_WIDTH=3.
1. Reset: hold rst_n=0 with switch=1 for 10 cycles -> clean=0, rise=0, fall=0 throughout. Assert rst_n=0 mid-cycle -> outputs clear without a clk edge.
2. Clean press: switch 0->1 before posedge 1, held -> clean=1 from posedge 7; rise=1 for exactly the cycle after posedge 7; fall stays 0.
3. Bounce rejection: switch high 3 cycles, low 1 cycle, high again and held -> no rise during the bounce; clean rises exactly 7 edges after the final 0->1.
4. Release: from clean=1, switch 1->0 held -> clean=0 at posedge 7 after the change; fall one-cycle pulse.
5. Reset mid-operation: drive rst_n low during WAIT_HIGH with cnt=2, release with switch still 1 -> state restarts from IDLE_LOW; clean rises 7 edges after release.
6. Macro off: repeat scenario 2 without DEBOUNCE_EDGE_PULSE_EN -> identical clean timing; rise and fall constantly 0.
